// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Handles load-use stalls, branch flushes, MUL/DIV sequencing, stall statistics and the timeout flag.
module hazard_controller #(
    parameter int ADDR_W     = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_IFID,
    input  logic [ADDR_W-1:0] rs2_IFID,
    input  logic              uses_rs2_IFID,
    input  logic [ADDR_W-1:0] rd_IDEX,
    input  logic              MemRead_IDEX,
    input  logic              branch_taken_EX,
    input  logic              md_req_IDEX,
    input  logic              md_done,
    output logic              stall_PC,
    output logic              stall_IFID,
    output logic              flush_IFID,
    output logic              bubble_IDEX,
    output logic              stall_IDEX,
    output logic              bubble_EXMEM,
    output logic              md_start,
    output logic              md_busy,
    output logic              md_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int MDC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [MDC_W-1:0]   r_md_cnt;
    logic               r_md_timeout;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic w_load_use;
    logic w_md_expired;
    logic w_md_hold;

    assign w_load_use = MemRead_IDEX && (rd_IDEX != '0) &&
                        ((rd_IDEX == rs1_IFID) || (uses_rs2_IFID && (rd_IDEX == rs2_IFID)));

    assign w_md_expired = (r_md_cnt == MD_LAST);

    // The front of the pipe stays frozen until the unit answers or the wait budget runs out.
    assign w_md_hold = !md_done && !w_md_expired;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        stall_PC     = 1'b0;
        stall_IFID   = 1'b0;
        flush_IFID   = 1'b0;
        bubble_IDEX  = 1'b0;
        stall_IDEX   = 1'b0;
        bubble_EXMEM = 1'b0;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_EX) begin
                        flush_IFID  = 1'b1;
                        bubble_IDEX = 1'b1;
                    end else if (md_req_IDEX) begin
                        md_start     = 1'b1;
                        stall_PC     = 1'b1;
                        stall_IFID   = 1'b1;
                        stall_IDEX   = 1'b1;
                        bubble_EXMEM = 1'b1;
                    end else if (w_load_use) begin
                        stall_PC    = 1'b1;
                        stall_IFID  = 1'b1;
                        bubble_IDEX = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    md_busy = 1'b1;
                    if (w_md_hold) begin
                        stall_PC     = 1'b1;
                        stall_IFID   = 1'b1;
                        stall_IDEX   = 1'b1;
                        bubble_EXMEM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_md_cnt       <= '0;
            r_md_timeout   <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (stall_PC && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (!branch_taken_EX && md_req_IDEX) begin
                        r_state  <= ST_MD_WAIT;
                        r_md_cnt <= '0;
                    end
                end
                ST_MD_WAIT: begin
                    r_md_cnt <= r_md_cnt + 1'b1;
                    if (md_done) begin
                        r_state <= ST_RUN;
                    end else if (w_md_expired) begin
                        r_state      <= ST_RUN;
                        r_md_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign md_timeout   = r_md_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule
